operand_queue_mbc: RTL and testbench
====================================

Name: operand_queue_mbc

Overview:
- Parametrised in-order operand queue for the issue stage.
- Each entry holds an opcode, a data word and a producer tag; tag 0 means the data is valid.
- Snoops NUM_BC result-broadcast channels to fill pending entries.
- Presents the head entry to the execution unit and pops it on acknowledge once the head is ready.

Parameters:
- DATA_W, 32, operand/broadcast data width
- TAG_W, 5, producer tag width; tag value 0 reserved for "ready"
- OP_W, 1, opcode width
- DEPTH, 8, entry count, power of two, at least 2
- NUM_BC, 2, number of broadcast channels

Ports:
- clk  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- WEN  in  1  push request
- dataIn  in  DATA_W  pushed data
- labelIn  in  TAG_W  pushed tag (0 = data valid)
- opIN  in  OP_W  pushed opcode
- isFull  out  1  count == DEPTH
- count  out  $clog2(DEPTH)+1  occupied entries
- BCEN  in  NUM_BC  per-channel broadcast valid
- BClabel  in  NUM_BC*TAG_W  packed tags, channel i at [i*TAG_W +: TAG_W]
- BCdata  in  NUM_BC*DATA_W  packed data, same packing
- require  out  1  head valid and head tag == 0
- requireAC  in  1  pop acknowledge
- opOut  out  OP_W  head opcode
- dataOut  out  DATA_W  head data
- labelOut  out  TAG_W  head tag

Interface: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (RST=1, any time, including mid-operation):
  - head, tail and count go to 0; all entry valid bits and tags are cleared.
  - Outputs: require=0, isFull=0, count=0, opOut/dataOut/labelOut=0.
- Storage: circular buffer, head/tail pointers $clog2(DEPTH) bits, wrap DEPTH-1 -> 0.
- Outputs:
  - opOut/dataOut/labelOut/require/isFull/count are combinational from registered state only. No input-to-output paths.
  - When the queue is empty, opOut/dataOut/labelOut read as 0.
- Pop:
  - Occurs on a clock edge with requireAC=1 and require=1. head advances and count decrements.
  - requireAC while require=0 is ignored.
  - A non-ready head blocks all entries behind it; issue is strictly in order.
- Push:
  - Occurs on a clock edge with WEN=1 and (isFull=0 or a pop in the same cycle). Entry written at tail, tail advances.
  - WEN while full without a pop is dropped; state is unchanged.
  - Push and pop in the same cycle leave count unchanged.
- Broadcast capture, every cycle, for every valid entry with tag != 0:
  - If some channel i has BCEN[i]=1 and BClabel_i equals the entry tag, set data <= BCdata_i and tag <= 0.
  - If several channels match, the lowest index wins.
  - BClabel_i == 0 never matches.
- Write-time bypass:
  - A pushed entry with labelIn != 0 that matches an active broadcast in the same cycle is stored with the broadcast data and tag 0.
  - The pushed data is discarded.
- Latency:
  - A ready push reaches the head of an empty queue and asserts require the cycle after the push edge.
  - A broadcast matching the head raises require the cycle after the broadcast edge.
- An entry being popped is not updated by a same-cycle broadcast.

Optional Feature:
- Macro QUEUE_FLUSH_EN.
- Defined:
  - Adds input flush (1 bit). On a clock edge with flush=1, head=tail=count=0 and all valid bits are cleared.
  - flush has priority over push, pop and broadcast in that cycle.
  - Outputs follow the empty-queue values next cycle.
- Undefined: no flush port and no flush logic; the queue can only be emptied by popping or RST.

Test Plan:
- Reset, then push (op=0, data=20, tag=0) -> next cycle require=1, dataOut=20, labelOut=0, count=1. Pulse requireAC -> count=0, require=0.
- Push tag=4 data=x, then broadcast ch0 tag=4 data=25 -> next cycle labelOut=0, dataOut=25, require=1. Broadcast tag=4 again after capture -> no change.
- Head tag=5, second entry tag=0 data=7, requireAC held high -> require stays 0 and no pop. Broadcast ch1 tag=5 data=1 -> pops data=1, then data=7.
- Same cycle: push tag=2 and broadcast ch1 tag=2 data=10 -> stored entry has labelOut=0 and dataOut=10 when it reaches the head. Ch0 and ch1 both broadcast tag=3 (data 11, 12) to a pending tag-3 entry -> captures 11.
- Fill 8 entries -> isFull=1. WEN alone -> count stays 8. WEN with a pop -> count stays 8, new entry at wrapped tail. Drain all 8 -> FIFO order preserved across wrap.
- Assert RST mid-stream with 5 entries -> all outputs 0 immediately, without waiting for a clock edge. With QUEUE_FLUSH_EN: flush while pushing -> count=0 next cycle and the push is dropped.

Source files
------------

// File: rtl/operand_queue_mbc.sv
`default_nettype none
// ============================================================================
// Module      : operand_queue_mbc
// Description : In-order operand queue for the issue stage. Each entry holds
//               an opcode, a data word and a producer tag (tag 0 = ready).
//               Pending entries snoop NUM_BC result-broadcast channels. The
//               head entry is offered to the execution unit and popped on
//               acknowledge once it is ready.
// Optional    : define QUEUE_FLUSH_EN to add a synchronous 'flush' input.
// Ports       : clk, RST (async, active-high)
//               push side  : WEN, dataIn, labelIn, opIN, isFull, count
//               broadcast  : BCEN, BClabel, BCdata (channel i at slice i)
//               issue side : require, requireAC, opOut, dataOut, labelOut
// Revision    : 1.0 - initial release
// ============================================================================
module operand_queue_mbc #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int OP_W   = 1,
    parameter int DEPTH  = 8,
    parameter int NUM_BC = 2
) (
    input  logic                       clk,
`ifdef QUEUE_FLUSH_EN
    input  logic                       flush,
`endif
    input  logic                       RST,
    input  logic                       WEN,
    input  logic [DATA_W-1:0]          dataIn,
    input  logic [TAG_W-1:0]           labelIn,
    input  logic [OP_W-1:0]            opIN,
    output logic                       isFull,
    output logic [$clog2(DEPTH):0]     count,
    input  logic [NUM_BC-1:0]          BCEN,
    input  logic [NUM_BC*TAG_W-1:0]    BClabel,
    input  logic [NUM_BC*DATA_W-1:0]   BCdata,
    output logic                       require,
    input  logic                       requireAC,
    output logic [OP_W-1:0]            opOut,
    output logic [DATA_W-1:0]          dataOut,
    output logic [TAG_W-1:0]           labelOut
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEPTH);

    logic [OP_W-1:0]   r_op    [DEPTH];
    logic [DATA_W-1:0] r_data  [DEPTH];
    logic [TAG_W-1:0]  r_tag   [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_nonempty;
    logic              w_full;
    logic              w_ready;
    logic              w_pop;
    logic              w_push;
    logic [DEPTH-1:0]  w_hit;
    logic [DATA_W-1:0] w_hit_data [DEPTH];
    logic              w_in_hit;
    logic [DATA_W-1:0] w_in_data;

    // Outputs depend on registered state only
    assign w_nonempty = (r_count != '0);
    assign w_full     = (r_count == c_cnt_max);
    assign w_ready    = w_nonempty && r_valid[r_head] && (r_tag[r_head] == '0);
    assign w_pop      = requireAC && w_ready;
    // A full queue still accepts a push when the head leaves in the same cycle
    assign w_push     = WEN && (!w_full || w_pop);

    assign isFull   = w_full;
    assign count    = r_count;
    assign require  = w_ready;
    assign opOut    = w_nonempty ? r_op[r_head]   : '0;
    assign dataOut  = w_nonempty ? r_data[r_head] : '0;
    assign labelOut = w_nonempty ? r_tag[r_head]  : '0;

    // Broadcast match per stored entry and for the incoming push.
    // Channels are scanned high to low so the lowest matching index wins.
    always_comb begin
        w_in_hit  = 1'b0;
        w_in_data = '0;
        for (int e = 0; e < DEPTH; e++) begin
            w_hit[e]      = 1'b0;
            w_hit_data[e] = '0;
        end
        for (int c = NUM_BC - 1; c >= 0; c--) begin
            if (BCEN[c] && (BClabel[c*TAG_W +: TAG_W] != '0)) begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (BClabel[c*TAG_W +: TAG_W] == r_tag[e]) begin
                        w_hit[e]      = 1'b1;
                        w_hit_data[e] = BCdata[c*DATA_W +: DATA_W];
                    end
                end
                if (BClabel[c*TAG_W +: TAG_W] == labelIn) begin
                    w_in_hit  = 1'b1;
                    w_in_data = BCdata[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                r_op[e]   <= '0;
                r_data[e] <= '0;
                r_tag[e]  <= '0;
            end
        end else begin
`ifdef QUEUE_FLUSH_EN
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_valid <= '0;
            end else begin
`endif
            // Capture into pending entries; the entry leaving this cycle is skipped
            for (int e = 0; e < DEPTH; e++) begin
                if (r_valid[e] && w_hit[e] && !(w_pop && (PTR_W'(e) == r_head))) begin
                    r_data[e] <= w_hit_data[e];
                    r_tag[e]  <= '0;
                end
            end

            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_ptr_one;
            end

            // Placed after the pop so a full-queue push into the freed slot wins
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_op[r_tail]    <= opIN;
                r_data[r_tail]  <= w_in_hit ? w_in_data : dataIn;
                r_tag[r_tail]   <= w_in_hit ? '0 : labelIn;
                r_tail          <= r_tail + c_ptr_one;
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_one;
            end
`ifdef QUEUE_FLUSH_EN
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_operand_queue_mbc.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_queue_mbc
// Description : Directed self-checking bench for operand_queue_mbc with
//               hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_queue_mbc;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        WEN = 1'b0;
    logic [31:0] dataIn = '0;
    logic [4:0]  labelIn = '0;
    logic [0:0]  opIN = '0;
    logic        isFull;
    logic [3:0]  count;
    logic [1:0]  BCEN = '0;
    logic [9:0]  BClabel = '0;
    logic [63:0] BCdata = '0;
    logic        require;
    logic        requireAC = 1'b0;
    logic [0:0]  opOut;
    logic [31:0] dataOut;
    logic [4:0]  labelOut;
`ifdef QUEUE_FLUSH_EN
    logic        flush = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    operand_queue_mbc dut (
        .clk       (clk),
`ifdef QUEUE_FLUSH_EN
        .flush     (flush),
`endif
        .RST       (RST),
        .WEN       (WEN),
        .dataIn    (dataIn),
        .labelIn   (labelIn),
        .opIN      (opIN),
        .isFull    (isFull),
        .count     (count),
        .BCEN      (BCEN),
        .BClabel   (BClabel),
        .BCdata    (BCdata),
        .require   (require),
        .requireAC (requireAC),
        .opOut     (opOut),
        .dataOut   (dataOut),
        .labelOut  (labelOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic op, input logic [31:0] d, input logic [4:0] t);
        WEN = 1'b1; opIN = op; dataIn = d; labelIn = t;
        step();
        WEN = 1'b0;
    endtask

    task automatic pop();
        requireAC = 1'b1;
        step();
        requireAC = 1'b0;
    endtask

    initial begin
        #3;
        check("rst_require", require, 0);
        check("rst_isFull", isFull, 0);
        check("rst_count", count, 0);
        check("rst_dataOut", dataOut, 0);
        check("rst_labelOut", labelOut, 0);
        step();
        RST = 1'b0;

        // Ready push then pop
        push(1'b0, 32'd20, 5'd0);
        check("p1_require", require, 1);
        check("p1_dataOut", dataOut, 20);
        check("p1_labelOut", labelOut, 0);
        check("p1_count", count, 1);
        pop();
        check("p1_pop_count", count, 0);
        check("p1_pop_require", require, 0);

        // Pending entry captured by broadcast ch0
        push(1'b1, 32'd99, 5'd4);
        check("bc_pend_label", labelOut, 4);
        check("bc_pend_require", require, 0);
        BCEN = 2'b01; BClabel = {5'd0, 5'd4}; BCdata = {32'd0, 32'd25};
        step();
        BCEN = 2'b00;
        check("bc_label", labelOut, 0);
        check("bc_data", dataOut, 25);
        check("bc_require", require, 1);
        check("bc_op", opOut, 1);
        BCEN = 2'b01; BClabel = {5'd0, 5'd4}; BCdata = {32'd0, 32'd77};
        step();
        BCEN = 2'b00;
        check("bc_again_data", dataOut, 25);
        pop();

        // Blocked head: requireAC held, nothing pops until the head is ready
        push(1'b0, 32'd0, 5'd5);
        push(1'b0, 32'd7, 5'd0);
        requireAC = 1'b1;
        step();
        check("blk_count", count, 2);
        check("blk_require", require, 0);
        BCEN = 2'b10; BClabel = {5'd5, 5'd0}; BCdata = {32'd1, 32'd0};
        step();
        BCEN = 2'b00;
        check("blk_head_data", dataOut, 1);
        check("blk_head_require", require, 1);
        check("blk_head_count", count, 2);
        step();
        check("blk_second_data", dataOut, 7);
        check("blk_second_count", count, 1);
        step();
        requireAC = 1'b0;
        check("blk_empty_count", count, 0);

        // Write-time bypass
        WEN = 1'b1; opIN = 1'b0; dataIn = 32'd55; labelIn = 5'd2;
        BCEN = 2'b10; BClabel = {5'd2, 5'd0}; BCdata = {32'd10, 32'd0};
        step();
        WEN = 1'b0; BCEN = 2'b00;
        check("byp_label", labelOut, 0);
        check("byp_data", dataOut, 10);
        check("byp_require", require, 1);
        pop();

        // Two channels match: lowest index wins
        push(1'b0, 32'd0, 5'd3);
        BCEN = 2'b11; BClabel = {5'd3, 5'd3}; BCdata = {32'd12, 32'd11};
        step();
        BCEN = 2'b00;
        check("prio_data", dataOut, 11);
        pop();
        check("prio_count", count, 0);

        // Fill, overflow, push+pop when full, drain across wrap
        for (int i = 0; i < 8; i++) push(1'(i), 32'd100 + 32'(i), 5'd0);
        check("full_isFull", isFull, 1);
        check("full_count", count, 8);
        push(1'b0, 32'd200, 5'd0);
        check("ovf_count", count, 8);
        check("ovf_head", dataOut, 100);
        WEN = 1'b1; opIN = 1'b0; dataIn = 32'd108; labelIn = 5'd0; requireAC = 1'b1;
        step();
        WEN = 1'b0; requireAC = 1'b0;
        check("pp_count", count, 8);
        check("pp_isFull", isFull, 1);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain_%0d", i), dataOut, 32'd100 + 32'(i));
            pop();
        end
        check("drain_count", count, 0);
        check("drain_isFull", isFull, 0);
        check("drain_dataOut", dataOut, 0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) push(1'b1, 32'd300 + 32'(i), 5'd0);
        check("pre_rst_count", count, 5);
        #2;
        RST = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_require", require, 0);
        check("arst_dataOut", dataOut, 0);
        check("arst_opOut", opOut, 0);
        check("arst_labelOut", labelOut, 0);
        step();
        RST = 1'b0;
        step();
        check("post_rst_count", count, 0);

`ifdef QUEUE_FLUSH_EN
        push(1'b0, 32'd1, 5'd0);
        push(1'b0, 32'd2, 5'd0);
        check("pre_flush_count", count, 2);
        flush = 1'b1; WEN = 1'b1; dataIn = 32'd9; labelIn = 5'd0;
        step();
        flush = 1'b0; WEN = 1'b0;
        check("flush_count", count, 0);
        check("flush_require", require, 0);
        check("flush_dataOut", dataOut, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
